// File: rtl/prog_loader_if.sv
// Byte-stream handshake plus RAM write port shared between the host side and the loader.
interface prog_loader_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    // Host/byte-source side: offers bytes, observes RAM writes.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata
    );

    // Loader side.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ram_we,
        output ram_addr,
        output ram_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader: SYNC, LEN, LEN payload bytes, CHK; writes payload to RAM from
// address 0 and releases the CPU only once the checksum is good.
module prog_loader #(
    parameter int unsigned           ADDR_WIDTH = 4,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hA5
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         load_done,
    output logic         load_error
);
    localparam int unsigned CW  = ADDR_WIDTH + 1;
    localparam int unsigned CAP = 1 << ADDR_WIDTH;
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [2:0] {StIdle, StLen, StData, StCheck, StDone, StError} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         len_q, len_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  in_ready_q, in_ready_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;

    logic                  accept;
    logic                  is_sync;
    logic                  len_bad;
    logic [CW-1:0]         count_inc;
    logic [DATA_WIDTH-1:0] sum_inc;

    assign accept    = bus.in_valid && in_ready_q;
    assign is_sync   = (bus.in_data == SYNC_BYTE);
    assign len_bad   = (bus.in_data == '0) || (32'(bus.in_data) > CAP);
    assign count_inc = count_q + ONE;
    assign sum_inc   = sum_q + bus.in_data;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        len_d        = len_q;
        sum_d        = sum_q;
        in_ready_d   = 1'b1;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                // Only a sync byte (re)starts a frame; anything else is swallowed.
                if (accept && is_sync) begin
                    state_d      = StLen;
                    count_d      = '0;
                    sum_d        = '0;
                    load_done_d  = 1'b0;
                    load_error_d = 1'b0;
                    cpu_hold_d   = 1'b1;
                end
            end
            StLen: begin
                if (accept) begin
                    if (len_bad) begin
                        state_d      = StError;
                        load_error_d = 1'b1;
                        cpu_hold_d   = 1'b1;
                    end else begin
                        len_d   = CW'(bus.in_data);
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = count_q[ADDR_WIDTH-1:0];
                    ram_wdata_d = bus.in_data;
                    sum_d       = sum_inc;
                    count_d     = count_inc;
                    // Stall the write cycle so at most one byte lands every two cycles.
                    in_ready_d  = 1'b0;
                    if (count_inc == len_q) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (accept) begin
                    if (sum_inc == '0) begin
                        state_d     = StDone;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        state_d      = StError;
                        load_error_d = 1'b1;
                        cpu_hold_d   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            count_q      <= '0;
            len_q        <= '0;
            sum_q        <= '0;
            in_ready_q   <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            len_q        <= len_d;
            sum_q        <= sum_d;
            in_ready_q   <= in_ready_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign load_done     = load_done_q;
    assign load_error    = load_error_q;
endmodule
